// File: rtl/dcls_lockstep_checker_if.sv
// rtl/dcls_lockstep_checker_if.sv - control, core-output and status bundle for the lockstep checker
interface dcls_lockstep_checker_if #(
    parameter int NUM_SIGNALS = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_DELAY   = 7,
    parameter int CNT_W       = 16,
    parameter int THR_W       = 4
);
    localparam int DLY_W = $clog2(MAX_DELAY + 1);

    logic                                   chk_en;
    logic [DLY_W-1:0]                       delay_sel;
    logic [NUM_SIGNALS-1:0]                 sig_mask;
    logic [THR_W-1:0]                       err_threshold;
    logic                                   err_clr;
    logic [NUM_SIGNALS-1:0][DATA_WIDTH-1:0] core0_out;
    logic [NUM_SIGNALS-1:0][DATA_WIDTH-1:0] core1_out;

    logic                                   mismatch_now;
    logic                                   fault;
    logic [NUM_SIGNALS-1:0]                 fault_vector;
    logic [CNT_W-1:0]                       mismatch_count;
    logic [1:0]                             state;

    modport master (
        output chk_en, delay_sel, sig_mask, err_threshold, err_clr, core0_out, core1_out,
        input  mismatch_now, fault, fault_vector, mismatch_count, state
    );

    modport slave (
        input  chk_en, delay_sel, sig_mask, err_threshold, err_clr, core0_out, core1_out,
        output mismatch_now, fault, fault_vector, mismatch_count, state
    );
endinterface

// File: rtl/dcls_lockstep_checker.sv
// rtl/dcls_lockstep_checker.sv - dual-core lockstep output checker with alignment, masking and fault filtering
module dcls_lockstep_checker #(
    parameter int NUM_SIGNALS = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_DELAY   = 7,
    parameter int CNT_W       = 16,
    parameter int THR_W       = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dcls_lockstep_checker_if.slave  bus
);
    localparam int DLY_W = $clog2(MAX_DELAY + 1);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'b00,
        ST_WARMUP   = 2'b01,
        ST_CHECK    = 2'b10,
        ST_FAULT    = 2'b11
    } state_t;

    typedef logic [NUM_SIGNALS-1:0][DATA_WIDTH-1:0] word_vec_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    word_vec_t              r_pipe [1:MAX_DELAY];
    logic [DLY_W-1:0]       r_dly;
    logic [DLY_W-1:0]       r_warm;
    logic [DLY_W-1:0]       w_warm_nxt;
    logic [THR_W-1:0]       r_consec;
    logic [THR_W-1:0]       w_consec_nxt;
    logic                   r_mnow;
    logic                   w_mnow_nxt;
    logic [NUM_SIGNALS-1:0] r_fv;
    logic [NUM_SIGNALS-1:0] w_fv_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;

    logic [DLY_W-1:0]       w_d;
    logic [DLY_W-1:0]       w_d_min1;
    word_vec_t              w_a0;
    logic [NUM_SIGNALS-1:0] w_mm;
    logic                   w_any_mm;
    logic [THR_W-1:0]       w_thr;
    logic [THR_W:0]         w_consec_inc;

    // Only lag codes that can exceed MAX_DELAY need a clamp
    generate
        if ((2 ** DLY_W) - 1 > MAX_DELAY) begin : g_clamp
            assign w_d = (bus.delay_sel > DLY_W'(MAX_DELAY)) ? DLY_W'(MAX_DELAY) : bus.delay_sel;
        end else begin : g_no_clamp
            assign w_d = bus.delay_sel;
        end
    endgenerate

    // A zero lag still needs one warm-up cycle; a zero threshold means fault on first mismatch
    assign w_d_min1     = (w_d == '0) ? DLY_W'(1) : w_d;
    assign w_thr        = (bus.err_threshold == '0) ? THR_W'(1) : bus.err_threshold;
    assign w_consec_inc = {1'b0, r_consec} + (THR_W + 1)'(1);

    // Core0 delay line, shifting in every state so it is already primed when checking starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= MAX_DELAY; k++) r_pipe[k] <= '0;
        end else begin
            r_pipe[1] <= bus.core0_out;
            for (int k = 2; k <= MAX_DELAY; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    // Select the core0 tap that lines up with the lagging core1 outputs
    always_comb begin
        w_a0 = bus.core0_out;
        for (int k = 1; k <= MAX_DELAY; k++) begin
            if (w_d == DLY_W'(k)) w_a0 = r_pipe[k];
        end
    end

    // Per-word masked inequality
    always_comb begin
        w_mm = '0;
        for (int i = 0; i < NUM_SIGNALS; i++) begin
            w_mm[i] = (w_a0[i] != bus.core1_out[i]) & bus.sig_mask[i];
        end
    end

    assign w_any_mm = |w_mm;

    // Next-state and next-value decode; err_clr outranks everything, FAULT then holds
    always_comb begin
        w_state_nxt  = r_state;
        w_warm_nxt   = r_warm;
        w_consec_nxt = r_consec;
        w_mnow_nxt   = 1'b0;
        w_fv_nxt     = r_fv;
        w_cnt_nxt    = r_cnt;
        if (bus.err_clr) begin
            w_fv_nxt     = '0;
            w_cnt_nxt    = '0;
            w_consec_nxt = '0;
            if (bus.chk_en) begin
                w_state_nxt = ST_WARMUP;
                w_warm_nxt  = w_d_min1;
            end else begin
                w_state_nxt = ST_DISABLED;
            end
        end else if (r_state == ST_FAULT) begin
            w_state_nxt = ST_FAULT;
        end else if (!bus.chk_en) begin
            w_state_nxt  = ST_DISABLED;
            w_consec_nxt = '0;
        end else begin
            case (r_state)
                ST_DISABLED: begin
                    w_state_nxt = ST_WARMUP;
                    w_warm_nxt  = w_d_min1;
                end
                ST_WARMUP: begin
                    if (r_warm == DLY_W'(1)) w_state_nxt = ST_CHECK;
                    else                     w_warm_nxt  = r_warm - 1'b1;
                end
                ST_CHECK: begin
                    if (bus.delay_sel != r_dly) begin
                        // Lag changed: this cycle's compare is meaningless, realign first
                        w_state_nxt  = ST_WARMUP;
                        w_warm_nxt   = w_d_min1;
                        w_consec_nxt = '0;
                    end else if (w_any_mm) begin
                        w_mnow_nxt   = 1'b1;
                        w_fv_nxt     = r_fv | w_mm;
                        if (!(&r_cnt)) w_cnt_nxt = r_cnt + 1'b1;
                        w_consec_nxt = w_consec_inc[THR_W-1:0];
                        if (w_consec_inc >= {1'b0, w_thr}) w_state_nxt = ST_FAULT;
                    end else begin
                        w_consec_nxt = '0;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // State and status registers; the lag copy tracks delay_sel every cycle for change detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_DISABLED;
            r_dly    <= '0;
            r_warm   <= '0;
            r_consec <= '0;
            r_mnow   <= 1'b0;
            r_fv     <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_dly    <= bus.delay_sel;
            r_warm   <= w_warm_nxt;
            r_consec <= w_consec_nxt;
            r_mnow   <= w_mnow_nxt;
            r_fv     <= w_fv_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign bus.mismatch_now   = r_mnow;
    assign bus.fault          = (r_state == ST_FAULT);
    assign bus.fault_vector   = r_fv;
    assign bus.mismatch_count = r_cnt;
    assign bus.state          = r_state;
endmodule
